// File: rtl/serial_frame_rx_if.sv
// ----------------------------------------------------------------------------
// serial_frame_rx_if
// Bundles the serial line and the recovered-word outputs of serial_frame_rx.
//   SerialDin     serial line into the receiver (idles high)
//   ParallelDout  last received data word
//   DoutValid     one-cycle strobe: ParallelDout and the flags were updated
//   ParityErr     parity mismatch on the last frame
//   FrameErr      stop bit was 0 on the last frame
//   Busy          receiver is not idle
// Modports: master = line driver / word consumer, slave = the receiver.
// ----------------------------------------------------------------------------
interface serial_frame_rx_if #(
    parameter int WIDTH = 4
);
    logic             SerialDin;
    logic [WIDTH-1:0] ParallelDout;
    logic             DoutValid;
    logic             ParityErr;
    logic             FrameErr;
    logic             Busy;

    modport master (
        output SerialDin,
        input  ParallelDout, DoutValid, ParityErr, FrameErr, Busy
    );

    modport slave (
        input  SerialDin,
        output ParallelDout, DoutValid, ParityErr, FrameErr, Busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// ----------------------------------------------------------------------------
// serial_frame_rx
// Framed serial receiver: start(0), WIDTH data bits LSB-first, parity, stop(1).
// Each bit lasts CLKS_PER_BIT clocks; bits are sampled at mid-bit, timed from
// the clock edge on which the falling start edge was first seen.
// Ports:
//   Clk   system clock, rising edge
//   Rst   asynchronous active-high reset
//   bus   serial_frame_rx_if.slave (SerialDin in; ParallelDout, DoutValid,
//         ParityErr, FrameErr, Busy out -- all outputs registered)
// ----------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic              Clk,
    input  logic              Rst,
    serial_frame_rx_if.slave  bus
);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cyc;
    logic [BIT_W-1:0] r_bit;
    logic [WIDTH-1:0] r_shift;
    logic             r_perr_pend;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_perr;
    logic             r_ferr;
    logic             r_busy;

    logic             w_din;
    logic             w_bit_end;

    assign w_din     = bus.SerialDin;
    assign w_bit_end = (r_cyc == BIT_END);

    // Data arrives LSB-first, so each new bit enters at the top and D0 ends
    // up in bit 0 once WIDTH bits have been shifted in.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                  input logic             b);
        logic [WIDTH-1:0] t;
        t           = s >> 1;
        t[WIDTH-1]  = b;
        return t;
    endfunction

    function automatic logic parity_err(input logic [WIDTH-1:0] data,
                                        input logic             par);
        return (^data) ^ par ^ PARITY_ODD;
    endfunction

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_perr_pend <= 1'b0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // Busy is a registered view of the current state, so it trails
            // the state register by one edge.
            r_busy  <= (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (!w_din) begin
                        r_state <= S_START;
                        r_cyc   <= '0;
                    end
                end

                // Resample at mid start bit; a high line means the low was a
                // glitch and nothing is reported.
                S_START: begin
                    if (r_cyc == HALF_END) begin
                        r_cyc   <= '0;
                        r_bit   <= '0;
                        r_state <= w_din ? S_IDLE : S_DATA;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_shift <= shift_in(r_shift, w_din);
                        if (r_bit == LAST_BIT) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cyc       <= '0;
                        r_perr_pend <= parity_err(r_shift, w_din);
                        r_state     <= S_STOP;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end

                // Word and flags are published together, even on error.
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_dout  <= r_shift;
                        r_perr  <= r_perr_pend;
                        r_ferr  <= ~w_din;
                        r_valid <= 1'b1;
                        r_state <= w_din ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end

                // A low stop bit leaves the line low; wait for it to return
                // high so the held-low line is not taken as a new start.
                S_WAIT_HIGH: begin
                    if (w_din) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ParallelDout = r_dout;
    assign bus.DoutValid    = r_valid;
    assign bus.ParityErr    = r_perr;
    assign bus.FrameErr     = r_ferr;
    assign bus.Busy         = r_busy;

endmodule

// File: tb/tb_serial_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_serial_frame_rx
// Drives two receivers (even and odd parity) with the same frames; the odd
// receiver sees every parity bit inverted, so both must report the same words
// and no extra parity errors. Expected outputs come from a frame-level model
// updated once per frame.
// ----------------------------------------------------------------------------
module tb_serial_frame_rx;
    localparam int W     = 4;
    localparam int CPB   = 4;
    localparam int HALF  = CPB / 2;
    localparam int FRAME = (W + 3) * CPB;          // start + data + parity + stop
    localparam int VLD_AT = HALF + (W + 2) * CPB;  // edge of stop-bit sample

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_frame_rx_if #(.WIDTH(W)) ifE ();
    serial_frame_rx_if #(.WIDTH(W)) ifO ();

    serial_frame_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
        .Clk (clk),
        .Rst (rst),
        .bus (ifE.slave)
    );

    serial_frame_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .Clk (clk),
        .Rst (rst),
        .bus (ifO.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int vld_cyc[$];

    // frame-level reference state
    logic [W-1:0] m_dout;
    logic         m_perr_e, m_perr_o, m_ferr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic ev, input logic eb);
        chk("even.valid", ifE.DoutValid,    ev);
        chk("even.busy",  ifE.Busy,         eb);
        chk("even.dout",  ifE.ParallelDout, m_dout);
        chk("even.perr",  ifE.ParityErr,    m_perr_e);
        chk("even.ferr",  ifE.FrameErr,     m_ferr);
        chk("odd.valid",  ifO.DoutValid,    ev);
        chk("odd.busy",   ifO.Busy,         eb);
        chk("odd.dout",   ifO.ParallelDout, m_dout);
        chk("odd.perr",   ifO.ParityErr,    m_perr_o);
        chk("odd.ferr",   ifO.FrameErr,     m_ferr);
    endtask

    // Apply line values, let one rising edge pass, then check just after it.
    task automatic step(input logic le, input logic lo, input logic ev, input logic eb);
        ifE.SerialDin = le;
        ifO.SerialDin = lo;
        @(posedge clk);
        #1;
        cyc++;
        if (ifE.DoutValid === 1'b1) vld_cyc.push_back(cyc);
        check_all(ev, eb);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Line level for bit slot j of a frame: 0 start, 1..W data, W+1 parity, W+2 stop.
    function automatic logic frame_bit(input logic [W-1:0] d, input logic p,
                                       input logic s, input int j);
        if (j == 0)           return 1'b0;
        else if (j <= W)      return d[j-1];
        else if (j == W + 1)  return p;
        else                  return s;
    endfunction

    // Parity error iff the count of ones over data+parity misses the target.
    function automatic logic exp_perr(input logic [W-1:0] d, input logic p, input bit odd);
        int ones;
        ones = $countones(d) + int'(p);
        return ((ones % 2) == 1) != odd;
    endfunction

    task automatic send_frame(input logic [W-1:0] d, input logic p, input logic s,
                              input int low_tail);
        logic le, lo, eb, ln;
        int   j;
        for (int c = 0; c < FRAME; c++) begin
            j  = c / CPB;
            le = frame_bit(d, p, s, j);
            lo = (j == W + 1) ? ~le : le;
            if (c == VLD_AT) begin
                m_dout   = d;
                m_perr_e = exp_perr(d, p, 1'b0);
                m_perr_o = exp_perr(d, ~p, 1'b1);
                m_ferr   = ~s;
            end
            eb = ((c >= 1) && (c <= VLD_AT)) || ((c == FRAME - 1) && !s);
            step(le, lo, (c == VLD_AT), eb);
        end
        if (!s) begin
            for (int c = FRAME; c <= FRAME + low_tail + 1; c++) begin
                ln = (c >= FRAME + low_tail);
                step(ln, ln, 1'b0, (c <= FRAME + low_tail));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rd;
        logic         rp, rs;
        int           nv;

        m_dout = '0; m_perr_e = 1'b0; m_perr_o = 1'b0; m_ferr = 1'b0;
        ifE.SerialDin = 1'b1;
        ifO.SerialDin = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all(1'b0, 1'b0);
        rst = 1'b0;
        idle(3);

        // good frame, then same frame with wrong parity
        send_frame(4'b1011, 1'b1, 1'b1, 0);
        idle(2);
        send_frame(4'b1011, 1'b0, 1'b1, 0);
        idle(2);

        // framing error with the line held low, then a clean frame
        send_frame(4'b0101, 1'b0, 1'b0, 10);
        idle(1);
        send_frame(4'b0110, 1'b0, 1'b1, 0);
        idle(2);

        // one-cycle glitch: START resample sees high, back to idle
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);

        // reset during data bit 2
        for (int c = 0; c < 14; c++) begin
            rp = frame_bit(4'b1001, 1'b0, 1'b1, c / CPB);
            step(rp, rp, 1'b0, (c >= 1));
        end
        rst = 1'b1;
        #1;
        m_dout = '0; m_perr_e = 1'b0; m_perr_o = 1'b0; m_ferr = 1'b0;
        check_all(1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);
        send_frame(4'b1111, 1'b0, 1'b1, 0);
        idle(3);

        // back-to-back frames, no idle gap
        nv = vld_cyc.size();
        send_frame(4'b0001, 1'b1, 1'b1, 0);
        send_frame(4'b1000, 1'b1, 1'b1, 0);
        chk("b2b.pulses", vld_cyc.size() - nv, 2);
        if (vld_cyc.size() - nv == 2)
            chk("b2b.spacing", vld_cyc[nv+1] - vld_cyc[nv], FRAME);
        idle(2);

        // randomized frames, including framing errors and random gaps
        for (int k = 0; k < 24; k++) begin
            rd = W'($urandom_range(0, (1 << W) - 1));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 4) != 0);
            idle($urandom_range(0, 2));
            send_frame(rd, rp, rs, $urandom_range(0, 6));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
